// File: rtl/ysyx_22040895_lsu_pkg.sv
// ysyx_22040895_lsu_pkg
// Shared definitions for the load/store unit: FSM state encoding, lsuop
// field layout, access-size encoding and per-size helper functions.
// No ports; imported by ysyx_22040895_lsu and ysyx_22040895_lsu_align.
package ysyx_22040895_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    // lsuop[3] = store, lsuop[2] = unsigned load, lsuop[1:0] = size
    localparam int unsigned LSUOP_STORE_BIT    = 3;
    localparam int unsigned LSUOP_UNSIGNED_BIT = 2;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } lsu_size_e;

    // Address offset bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] size_align_bits(input lsu_size_e sz);
        case (sz)
            SZ_B:    return 3'b000;
            SZ_H:    return 3'b001;
            SZ_W:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    // Unshifted byte-enable pattern for an access size.
    function automatic logic [7:0] size_byte_mask(input lsu_size_e sz);
        case (sz)
            SZ_B:    return 8'h01;
            SZ_H:    return 8'h03;
            SZ_W:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_22040895_lsu_align.sv
// ysyx_22040895_lsu_align
// Combinational byte-lane logic for the LSU.
//   Store side: st_off_i/st_size_i/st_data_i -> st_data_o (lane-shifted data),
//               st_mask_o (byte enables).
//   Load side:  ld_off_i/ld_size_i/ld_unsigned_i/ld_rdata_i -> ld_data_o
//               (selected lane, sign- or zero-extended to XLEN).
module ysyx_22040895_lsu_align
    import ysyx_22040895_lsu_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [2:0]      st_off_i,
    input  lsu_size_e       st_size_i,
    input  logic [XLEN-1:0] st_data_i,
    output logic [XLEN-1:0] st_data_o,
    output logic [7:0]      st_mask_o,
    input  logic [2:0]      ld_off_i,
    input  lsu_size_e       ld_size_i,
    input  logic            ld_unsigned_i,
    input  logic [XLEN-1:0] ld_rdata_i,
    output logic [XLEN-1:0] ld_data_o
);

    logic [XLEN-1:0] ld_shifted;

    always_comb begin
        st_data_o  = st_data_i << {st_off_i, 3'b000};
        st_mask_o  = size_byte_mask(st_size_i) << st_off_i;

        // Bring the addressed lane down to bit 0, then extend from there.
        ld_shifted = ld_rdata_i >> {ld_off_i, 3'b000};
        case (ld_size_i)
            SZ_B: ld_data_o = ld_unsigned_i ? {{(XLEN-8){1'b0}}, ld_shifted[7:0]}
                                            : {{(XLEN-8){ld_shifted[7]}}, ld_shifted[7:0]};
            SZ_H: ld_data_o = ld_unsigned_i ? {{(XLEN-16){1'b0}}, ld_shifted[15:0]}
                                            : {{(XLEN-16){ld_shifted[15]}}, ld_shifted[15:0]};
            SZ_W: ld_data_o = ld_unsigned_i ? {{(XLEN-32){1'b0}}, ld_shifted[31:0]}
                                            : {{(XLEN-32){ld_shifted[31]}}, ld_shifted[31:0]};
            default: ld_data_o = ld_shifted;
        endcase
    end

endmodule

// File: rtl/ysyx_22040895_lsu.sv
// ysyx_22040895_lsu
// Load/store unit: accepts one EXU result at a time, either passes the ALU
// value through to writeback or performs a single memory load/store, and
// emits a one-cycle writeback pulse.
//   EXU side:  valid_i_lsu/ready_o_lsu handshake, memop_i_lsu, lsuop_i_lsu,
//              addr_i_lsu, wdata_i_lsu, rd_i_lsu.
//   Memory:    mem_req/we/addr/wdata/wmask out, mem_gnt/rvalid/rdata in.
//   Writeback: wb_valid/wen/rd/data out, misalign_o_lsu.
// Config macro: YSYX_22040895_MISALIGN_TRAP_EN -- when defined, misaligned
// H/W/D accesses retire immediately with misalign_o_lsu set and no memory
// request; when undefined, the address is aligned down to the access size.
module ysyx_22040895_lsu #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i_lsu,
    output logic            ready_o_lsu,
    input  logic            memop_i_lsu,
    input  logic [3:0]      lsuop_i_lsu,
    input  logic [XLEN-1:0] addr_i_lsu,
    input  logic [XLEN-1:0] wdata_i_lsu,
    input  logic [4:0]      rd_i_lsu,
    output logic            mem_req_o_lsu,
    output logic            mem_we_o_lsu,
    output logic [XLEN-1:0] mem_addr_o_lsu,
    output logic [XLEN-1:0] mem_wdata_o_lsu,
    output logic [7:0]      mem_wmask_o_lsu,
    input  logic            mem_gnt_i_lsu,
    input  logic            mem_rvalid_i_lsu,
    input  logic [XLEN-1:0] mem_rdata_i_lsu,
    output logic            wb_valid_o_lsu,
    output logic            wb_wen_o_lsu,
    output logic [4:0]      wb_rd_o_lsu,
    output logic [XLEN-1:0] wb_data_o_lsu,
    output logic            misalign_o_lsu
);
    import ysyx_22040895_lsu_pkg::*;

    lsu_state_e      state_q;
    logic            ready_q;
    logic            mem_req_q;
    logic            mem_we_q;
    logic [XLEN-1:0] mem_addr_q;
    logic [XLEN-1:0] mem_wdata_q;
    logic [7:0]      mem_wmask_q;
    logic            wb_valid_q;
    logic            wb_wen_q;
    logic [4:0]      wb_rd_q;
    logic [XLEN-1:0] wb_data_q;
    logic            misalign_q;

    // Latched load attributes used while waiting for read data.
    logic            is_store_q;
    logic [2:0]      ld_off_q;
    lsu_size_e       ld_size_q;
    logic            ld_unsigned_q;

    logic            accept;
    lsu_size_e       in_size;
    logic [2:0]      in_off;
    logic            in_misalign;
    logic [XLEN-1:0] st_data;
    logic [7:0]      st_mask;
    logic [XLEN-1:0] ld_data;

    always_comb begin
        accept  = valid_i_lsu & ready_q;
        in_size = lsu_size_e'(lsuop_i_lsu[1:0]);
        // Aligning down is harmless with trapping enabled: any access that
        // reaches memory there already has these bits clear.
        in_off  = addr_i_lsu[2:0] & ~size_align_bits(in_size);
`ifdef YSYX_22040895_MISALIGN_TRAP_EN
        in_misalign = |(addr_i_lsu[2:0] & size_align_bits(in_size));
`else
        in_misalign = 1'b0;
`endif
    end

    ysyx_22040895_lsu_align #(
        .XLEN(XLEN)
    ) u_align (
        .st_off_i      (in_off),
        .st_size_i     (in_size),
        .st_data_i     (wdata_i_lsu),
        .st_data_o     (st_data),
        .st_mask_o     (st_mask),
        .ld_off_i      (ld_off_q),
        .ld_size_i     (ld_size_q),
        .ld_unsigned_i (ld_unsigned_q),
        .ld_rdata_i    (mem_rdata_i_lsu),
        .ld_data_o     (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            ready_q       <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_wmask_q   <= '0;
            wb_valid_q    <= 1'b0;
            wb_wen_q      <= 1'b0;
            wb_rd_q       <= '0;
            wb_data_q     <= '0;
            misalign_q    <= 1'b0;
            is_store_q    <= 1'b0;
            ld_off_q      <= '0;
            ld_size_q     <= SZ_B;
            ld_unsigned_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ready_q    <= 1'b1;
                    wb_valid_q <= 1'b0;
                    wb_wen_q   <= 1'b0;
                    misalign_q <= 1'b0;
                    if (accept) begin
                        ready_q <= 1'b0;
                        wb_rd_q <= rd_i_lsu;
                        if (!memop_i_lsu) begin
                            state_q    <= ST_DONE;
                            wb_valid_q <= 1'b1;
                            wb_wen_q   <= (rd_i_lsu != 5'd0);
                            wb_data_q  <= addr_i_lsu;
                        end else if (in_misalign) begin
                            state_q    <= ST_DONE;
                            wb_valid_q <= 1'b1;
                            wb_data_q  <= '0;
                            misalign_q <= 1'b1;
                        end else begin
                            state_q       <= ST_REQ;
                            mem_req_q     <= 1'b1;
                            mem_we_q      <= lsuop_i_lsu[LSUOP_STORE_BIT];
                            mem_addr_q    <= {addr_i_lsu[XLEN-1:3], 3'b000};
                            mem_wdata_q   <= lsuop_i_lsu[LSUOP_STORE_BIT] ? st_data : '0;
                            mem_wmask_q   <= lsuop_i_lsu[LSUOP_STORE_BIT] ? st_mask : '0;
                            is_store_q    <= lsuop_i_lsu[LSUOP_STORE_BIT];
                            ld_off_q      <= in_off;
                            ld_size_q     <= in_size;
                            ld_unsigned_q <= lsuop_i_lsu[LSUOP_UNSIGNED_BIT];
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_gnt_i_lsu) begin
                        mem_req_q <= 1'b0;
                        if (is_store_q) begin
                            state_q    <= ST_DONE;
                            wb_valid_q <= 1'b1;
                            wb_data_q  <= '0;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid_i_lsu) begin
                        state_q    <= ST_DONE;
                        wb_valid_q <= 1'b1;
                        wb_wen_q   <= (wb_rd_q != 5'd0);
                        wb_data_q  <= ld_data;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    ready_q    <= 1'b1;
                    wb_valid_q <= 1'b0;
                    wb_wen_q   <= 1'b0;
                    misalign_q <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o_lsu     = ready_q;
    assign mem_req_o_lsu   = mem_req_q;
    assign mem_we_o_lsu    = mem_we_q;
    assign mem_addr_o_lsu  = mem_addr_q;
    assign mem_wdata_o_lsu = mem_wdata_q;
    assign mem_wmask_o_lsu = mem_wmask_q;
    assign wb_valid_o_lsu  = wb_valid_q;
    assign wb_wen_o_lsu    = wb_wen_q;
    assign wb_rd_o_lsu     = wb_rd_q;
    assign wb_data_o_lsu   = wb_data_q;
    assign misalign_o_lsu  = misalign_q;

endmodule

// File: tb/tb_ysyx_22040895_lsu.sv
module tb_ysyx_22040895_lsu;
    logic        clk;
    logic        rst;
    logic        valid_i_lsu;
    logic        ready_o_lsu;
    logic        memop_i_lsu;
    logic [3:0]  lsuop_i_lsu;
    logic [63:0] addr_i_lsu;
    logic [63:0] wdata_i_lsu;
    logic [4:0]  rd_i_lsu;
    logic        mem_req_o_lsu;
    logic        mem_we_o_lsu;
    logic [63:0] mem_addr_o_lsu;
    logic [63:0] mem_wdata_o_lsu;
    logic [7:0]  mem_wmask_o_lsu;
    logic        mem_gnt_i_lsu;
    logic        mem_rvalid_i_lsu;
    logic [63:0] mem_rdata_i_lsu;
    logic        wb_valid_o_lsu;
    logic        wb_wen_o_lsu;
    logic [4:0]  wb_rd_o_lsu;
    logic [63:0] wb_data_o_lsu;
    logic        misalign_o_lsu;

    int checks;
    int failures;

    ysyx_22040895_lsu #(.XLEN(64)) dut (
        .clk(clk), .rst(rst),
        .valid_i_lsu(valid_i_lsu), .ready_o_lsu(ready_o_lsu),
        .memop_i_lsu(memop_i_lsu), .lsuop_i_lsu(lsuop_i_lsu),
        .addr_i_lsu(addr_i_lsu), .wdata_i_lsu(wdata_i_lsu), .rd_i_lsu(rd_i_lsu),
        .mem_req_o_lsu(mem_req_o_lsu), .mem_we_o_lsu(mem_we_o_lsu),
        .mem_addr_o_lsu(mem_addr_o_lsu), .mem_wdata_o_lsu(mem_wdata_o_lsu),
        .mem_wmask_o_lsu(mem_wmask_o_lsu), .mem_gnt_i_lsu(mem_gnt_i_lsu),
        .mem_rvalid_i_lsu(mem_rvalid_i_lsu), .mem_rdata_i_lsu(mem_rdata_i_lsu),
        .wb_valid_o_lsu(wb_valid_o_lsu), .wb_wen_o_lsu(wb_wen_o_lsu),
        .wb_rd_o_lsu(wb_rd_o_lsu), .wb_data_o_lsu(wb_data_o_lsu),
        .misalign_o_lsu(misalign_o_lsu)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Present one transaction for a single cycle; caller is at a negedge with ready high.
    task automatic issue(input logic memop, input logic [3:0] op, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [4:0] rd);
        valid_i_lsu = 1'b1; memop_i_lsu = memop; lsuop_i_lsu = op;
        addr_i_lsu = addr; wdata_i_lsu = wdata; rd_i_lsu = rd;
        @(negedge clk);
        valid_i_lsu = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (ready_o_lsu !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", ready_o_lsu); end
        checks++; if (mem_req_o_lsu !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", mem_req_o_lsu); end
        checks++; if (wb_valid_o_lsu !== 1'b0) begin failures++; $display("FAIL rst_wbvalid got=%b exp=0", wb_valid_o_lsu); end
        checks++; if (wb_data_o_lsu !== 64'h0) begin failures++; $display("FAIL rst_wbdata got=%h exp=0", wb_data_o_lsu); end
        checks++; if (misalign_o_lsu !== 1'b0) begin failures++; $display("FAIL rst_misalign got=%b exp=0", misalign_o_lsu); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (ready_o_lsu !== 1'b1) begin failures++; $display("FAIL rst_ready_after got=%b exp=1", ready_o_lsu); end
    endtask

    task automatic test_idle_ignore();
        mem_gnt_i_lsu = 1'b1; mem_rvalid_i_lsu = 1'b1; mem_rdata_i_lsu = 64'hDEAD_BEEF_DEAD_BEEF;
        repeat (2) @(negedge clk);
        checks++; if (wb_valid_o_lsu !== 1'b0) begin failures++; $display("FAIL idle_gnt_wbvalid got=%b exp=0", wb_valid_o_lsu); end
        checks++; if (ready_o_lsu !== 1'b1) begin failures++; $display("FAIL idle_gnt_ready got=%b exp=1", ready_o_lsu); end
        mem_gnt_i_lsu = 1'b0; mem_rvalid_i_lsu = 1'b0;
    endtask

    task automatic test_passthrough();
        issue(1'b0, 4'b0000, 64'h1234, 64'h0, 5'd5);
        checks++; if (wb_valid_o_lsu !== 1'b1) begin failures++; $display("FAIL pt_wbvalid got=%b exp=1", wb_valid_o_lsu); end
        checks++; if (wb_data_o_lsu !== 64'h1234) begin failures++; $display("FAIL pt_data got=%h exp=1234", wb_data_o_lsu); end
        checks++; if (wb_wen_o_lsu !== 1'b1) begin failures++; $display("FAIL pt_wen got=%b exp=1", wb_wen_o_lsu); end
        checks++; if (wb_rd_o_lsu !== 5'd5) begin failures++; $display("FAIL pt_rd got=%0d exp=5", wb_rd_o_lsu); end
        checks++; if (mem_req_o_lsu !== 1'b0) begin failures++; $display("FAIL pt_req got=%b exp=0", mem_req_o_lsu); end
        @(negedge clk);
        checks++; if (wb_valid_o_lsu !== 1'b0) begin failures++; $display("FAIL pt_pulse got=%b exp=0", wb_valid_o_lsu); end
        checks++; if (ready_o_lsu !== 1'b1) begin failures++; $display("FAIL pt_ready got=%b exp=1", ready_o_lsu); end
        // rd = x0: retires but must not write.
        issue(1'b0, 4'b0000, 64'h55AA, 64'h0, 5'd0);
        checks++; if (wb_wen_o_lsu !== 1'b0 || wb_valid_o_lsu !== 1'b1) begin failures++; $display("FAIL pt_x0 got wen=%b valid=%b exp wen=0 valid=1", wb_wen_o_lsu, wb_valid_o_lsu); end
        @(negedge clk);
    endtask

    // Drive a granted load through to writeback; returns at the DONE negedge.
    task automatic load_run(input logic [3:0] op, input logic [63:0] addr, input logic [4:0] rd,
                            input logic [63:0] rdata, input int unsigned rv_delay);
        issue(1'b1, op, addr, 64'h0, rd);
        mem_gnt_i_lsu = 1'b1;
        @(negedge clk);
        mem_gnt_i_lsu = 1'b0;
        mem_rdata_i_lsu = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int unsigned i = 0; i < rv_delay; i++) @(negedge clk);
        mem_rvalid_i_lsu = 1'b1; mem_rdata_i_lsu = rdata;
        @(negedge clk);
        mem_rvalid_i_lsu = 1'b0;
    endtask

    task automatic test_load();
        load_run(4'b0000, 64'h0000_0000_0000_1003, 5'd7, 64'h0000_0000_8000_0000, 0);
        checks++; if (wb_valid_o_lsu !== 1'b1) begin failures++; $display("FAIL lb_latency got=%b exp=1", wb_valid_o_lsu); end
        checks++; if (wb_data_o_lsu !== 64'hFFFF_FFFF_FFFF_FF80) begin failures++; $display("FAIL lb_data got=%h exp=ffffffffffffff80", wb_data_o_lsu); end
        checks++; if (wb_wen_o_lsu !== 1'b1 || wb_rd_o_lsu !== 5'd7) begin failures++; $display("FAIL lb_wen got wen=%b rd=%0d exp wen=1 rd=7", wb_wen_o_lsu, wb_rd_o_lsu); end
        @(negedge clk);
        load_run(4'b0100, 64'h0000_0000_0000_1003, 5'd7, 64'h0000_0000_8000_0000, 0);
        checks++; if (wb_data_o_lsu !== 64'h80) begin failures++; $display("FAIL lbu_data got=%h exp=80", wb_data_o_lsu); end
        @(negedge clk);
        // Delayed rvalid: garbage on rdata must be ignored until rvalid.
        load_run(4'b0010, 64'h0000_0000_0000_2004, 5'd9, 64'h8000_1234_0000_0000, 2);
        checks++; if (wb_data_o_lsu !== 64'hFFFF_FFFF_8000_1234) begin failures++; $display("FAIL lw_data got=%h exp=ffffffff80001234", wb_data_o_lsu); end
        @(negedge clk);
        load_run(4'b0101, 64'h0000_0000_0000_2006, 5'd0, 64'h9ABC_0000_0000_0000, 0);
        checks++; if (wb_data_o_lsu !== 64'h9ABC || wb_wen_o_lsu !== 1'b0) begin failures++; $display("FAIL lhu_x0 got data=%h wen=%b exp data=9abc wen=0", wb_data_o_lsu, wb_wen_o_lsu); end
        @(negedge clk);
    endtask

    task automatic test_store();
        issue(1'b1, 4'b1001, 64'h0000_0000_0000_2006, 64'hBEEF, 5'd3);
        for (int unsigned i = 0; i < 3; i++) begin
            checks++; if (mem_req_o_lsu !== 1'b1 || mem_we_o_lsu !== 1'b1) begin failures++; $display("FAIL sh_req_hold cyc=%0d got req=%b we=%b exp 1 1", i, mem_req_o_lsu, mem_we_o_lsu); end
            checks++; if (mem_addr_o_lsu !== 64'h2000 || mem_wmask_o_lsu !== 8'hC0 || mem_wdata_o_lsu !== 64'hBEEF_0000_0000_0000) begin failures++; $display("FAIL sh_bus cyc=%0d got addr=%h mask=%h data=%h exp 2000 c0 beef000000000000", i, mem_addr_o_lsu, mem_wmask_o_lsu, mem_wdata_o_lsu); end
            @(negedge clk);
        end
        mem_gnt_i_lsu = 1'b1;
        @(negedge clk);
        mem_gnt_i_lsu = 1'b0;
        checks++; if (wb_valid_o_lsu !== 1'b1 || wb_wen_o_lsu !== 1'b0 || mem_req_o_lsu !== 1'b0) begin failures++; $display("FAIL sh_done got valid=%b wen=%b req=%b exp 1 0 0", wb_valid_o_lsu, wb_wen_o_lsu, mem_req_o_lsu); end
        @(negedge clk);
        issue(1'b1, 4'b1000, 64'h0000_0000_0000_3005, 64'h0000_0000_0000_00A5, 5'd1);
        checks++; if (mem_wmask_o_lsu !== 8'h20 || mem_wdata_o_lsu !== 64'h0000_A500_0000_0000) begin failures++; $display("FAIL sb_bus got mask=%h data=%h exp 20 0000a50000000000", mem_wmask_o_lsu, mem_wdata_o_lsu); end
        mem_gnt_i_lsu = 1'b1;
        @(negedge clk);
        mem_gnt_i_lsu = 1'b0;
        @(negedge clk);
        issue(1'b1, 4'b1011, 64'h0000_0000_0000_3000, 64'h0123_4567_89AB_CDEF, 5'd1);
        checks++; if (mem_wmask_o_lsu !== 8'hFF || mem_wdata_o_lsu !== 64'h0123_4567_89AB_CDEF) begin failures++; $display("FAIL sd_bus got mask=%h data=%h exp ff 0123456789abcdef", mem_wmask_o_lsu, mem_wdata_o_lsu); end
        mem_gnt_i_lsu = 1'b1;
        @(negedge clk);
        mem_gnt_i_lsu = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_in_wait();
        issue(1'b1, 4'b0010, 64'h0000_0000_0000_4000, 64'h0, 5'd4);
        mem_gnt_i_lsu = 1'b1;
        @(negedge clk);
        mem_gnt_i_lsu = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (ready_o_lsu !== 1'b0 || mem_req_o_lsu !== 1'b0 || wb_valid_o_lsu !== 1'b0) begin failures++; $display("FAIL rstw_outputs got ready=%b req=%b valid=%b exp 0 0 0", ready_o_lsu, mem_req_o_lsu, wb_valid_o_lsu); end
        rst = 1'b0;
        mem_rvalid_i_lsu = 1'b1; mem_rdata_i_lsu = 64'h1111_2222_3333_4444;
        @(negedge clk);
        mem_rvalid_i_lsu = 1'b0;
        checks++; if (wb_valid_o_lsu !== 1'b0 || ready_o_lsu !== 1'b1) begin failures++; $display("FAIL rstw_discard got valid=%b ready=%b exp 0 1", wb_valid_o_lsu, ready_o_lsu); end
        @(negedge clk);
        checks++; if (wb_valid_o_lsu !== 1'b0) begin failures++; $display("FAIL rstw_late got valid=%b exp 0", wb_valid_o_lsu); end
    endtask

    task automatic test_misalign();
`ifdef YSYX_22040895_MISALIGN_TRAP_EN
        issue(1'b1, 4'b0010, 64'h0000_0000_0000_5002, 64'h0, 5'd6);
        checks++; if (wb_valid_o_lsu !== 1'b1 || misalign_o_lsu !== 1'b1) begin failures++; $display("FAIL mis_flag got valid=%b mis=%b exp 1 1", wb_valid_o_lsu, misalign_o_lsu); end
        checks++; if (mem_req_o_lsu !== 1'b0 || wb_wen_o_lsu !== 1'b0) begin failures++; $display("FAIL mis_noreq got req=%b wen=%b exp 0 0", mem_req_o_lsu, wb_wen_o_lsu); end
        @(negedge clk);
        checks++; if (misalign_o_lsu !== 1'b0) begin failures++; $display("FAIL mis_clear got=%b exp 0", misalign_o_lsu); end
`else
        issue(1'b1, 4'b0010, 64'h0000_0000_0000_5002, 64'h0, 5'd6);
        checks++; if (mem_req_o_lsu !== 1'b1 || mem_addr_o_lsu !== 64'h5000) begin failures++; $display("FAIL mis_req got req=%b addr=%h exp 1 5000", mem_req_o_lsu, mem_addr_o_lsu); end
        mem_gnt_i_lsu = 1'b1;
        @(negedge clk);
        mem_gnt_i_lsu = 1'b0;
        mem_rvalid_i_lsu = 1'b1; mem_rdata_i_lsu = 64'h1122_3344_5566_7788;
        @(negedge clk);
        mem_rvalid_i_lsu = 1'b0;
        checks++; if (wb_data_o_lsu !== 64'h5566_7788 || misalign_o_lsu !== 1'b0) begin failures++; $display("FAIL mis_align got data=%h mis=%b exp 0000000055667788 0", wb_data_o_lsu, misalign_o_lsu); end
        @(negedge clk);
`endif
    endtask

    task automatic test_back_to_back();
        issue(1'b0, 4'b0000, 64'hAAAA_0000_0000_0001, 64'h0, 5'd10);
        checks++; if (ready_o_lsu !== 1'b0) begin failures++; $display("FAIL b2b_busy got=%b exp 0", ready_o_lsu); end
        @(negedge clk);
        issue(1'b0, 4'b0000, 64'hBBBB_0000_0000_0002, 64'h0, 5'd11);
        checks++; if (wb_data_o_lsu !== 64'hBBBB_0000_0000_0002 || wb_rd_o_lsu !== 5'd11) begin failures++; $display("FAIL b2b_second got data=%h rd=%0d exp bbbb000000000002 11", wb_data_o_lsu, wb_rd_o_lsu); end
        @(negedge clk);
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; valid_i_lsu = 1'b0; memop_i_lsu = 1'b0; lsuop_i_lsu = 4'h0;
        addr_i_lsu = '0; wdata_i_lsu = '0; rd_i_lsu = '0;
        mem_gnt_i_lsu = 1'b0; mem_rvalid_i_lsu = 1'b0; mem_rdata_i_lsu = '0;
        test_reset();
        test_idle_ignore();
        test_passthrough();
        test_load();
        test_store();
        test_reset_in_wait();
        test_misalign();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
